// File: rtl/aes_pkg.sv
// Shared AES constants and types for the key expander and the cipher datapaths.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int RK_W    = 128;
  localparam int RK_N    = 11;
  localparam int SCHED_W = RK_W * RK_N;

  localparam logic [3:0] LAST_RND = 4'd10;

  // Index 0 is unused so that Rcon[r] lines up with round r.
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                         8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (as a^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse and conveniently maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b     = ginv(in_i);
    out_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
              ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expansion, one round key per round into an 11-slot schedule.
// Build option AES_KEYEXP_SBOX_PIPE_EN registers SubWord, making each round two cycles.
module aes_key_expander
  import aes_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               KEY_START,
  input  logic [RK_W-1:0]    KEY_IN,
  output logic [SCHED_W-1:0] KEY_SCHEDULE,
  output logic               KEY_DONE,
  output logic               KEY_BUSY
);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [RK_W-1:0] slot_q [RK_N];
  logic [RK_W-1:0] rk_q;
  logic            busy_q, done_q;

  logic [31:0]     rot, sub, temp;
  logic [31:0]     w0_d, w1_d, w2_d, w3_d;
  logic [RK_W-1:0] rk_d;
  logic            wr_en;

  // rk_q mirrors the most recently written slot, so no slot read mux is needed.
  assign rot = {rk_q[23:0], rk_q[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot[8*j +: 8]),
      .out_o (sub[8*j +: 8])
    );
  end

`ifdef AES_KEYEXP_SBOX_PIPE_EN
  logic [31:0] sub_q;
  logic        phase_q;
  assign temp  = sub_q ^ {RCON[cnt_q], 24'h0};
  assign wr_en = phase_q;
`else
  assign temp  = sub ^ {RCON[cnt_q], 24'h0};
  assign wr_en = 1'b1;
`endif

  assign w0_d = rk_q[127:96] ^ temp;
  assign w1_d = rk_q[95:64]  ^ w0_d;
  assign w2_d = rk_q[63:32]  ^ w1_d;
  assign w3_d = rk_q[31:0]   ^ w2_d;
  assign rk_d = {w0_d, w1_d, w2_d, w3_d};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < RK_N; r++) slot_q[r] <= '0;
`ifdef AES_KEYEXP_SBOX_PIPE_EN
      sub_q   <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (KEY_START) begin
            slot_q[0] <= KEY_IN;
            for (int r = 1; r < RK_N; r++) slot_q[r] <= '0;
            rk_q    <= KEY_IN;
            cnt_q   <= 4'd1;
            state_q <= EXPAND;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef AES_KEYEXP_SBOX_PIPE_EN
            phase_q <= 1'b0;
`endif
          end
        end
        EXPAND: begin
          if (cnt_q == 4'd0 || cnt_q > LAST_RND) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
`ifdef AES_KEYEXP_SBOX_PIPE_EN
            phase_q <= ~phase_q;
            if (!phase_q) sub_q <= sub;
`endif
            if (wr_en) begin
              slot_q[cnt_q] <= rk_d;
              rk_q          <= rk_d;
              if (cnt_q == LAST_RND) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < RK_N; r++) begin : g_sched
    assign KEY_SCHEDULE[SCHED_W-1-RK_W*r -: RK_W] = slot_q[r];
  end

  assign KEY_BUSY = busy_q;
  assign KEY_DONE = done_q;

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative AES-128 key expansion engine that sits directly upstream of the AES decryption core. It accepts a 128-bit cipher key on a start pulse and generates the eleven round keys, one per cycle. It presents them as a flat 1408-bit schedule together with a level done flag, which the core waits on before accepting its own start.

## Interface
- No parameters; AES-128 only.
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEY_START  in  1  one-cycle (or longer) request to expand KEY_IN; sampled on rising edge.
- KEY_IN  in  128  cipher key, byte 0 in bits [127:120]; sampled only on the accepting edge.
- KEY_SCHEDULE  out  1408  round key r (r = 0..10) at bits [1407-128r : 1280-128r]; key 0 = cipher key in MSBs.
- KEY_DONE  out  1  high while a complete schedule is valid.
- KEY_BUSY  out  1  high while expansion is in progress.

## Operation
- States: IDLE, EXPAND, DONE.
- IDLE or DONE with KEY_START=1 at an edge:
  - Slot 0 is loaded with KEY_IN.
  - Slots 1..10 are cleared to 0.
  - Round counter is set to 1; the FSM goes to EXPAND.
- EXPAND, each edge:
  - Compute w[4r..4r+3] from slot r-1 per FIPS-197 and write slot r.
  - temp = SubWord(RotWord(w[4r-1])) xor Rcon[r].
  - w[4r] = w[4r-4] xor temp; w[4r+i] = w[4r+i-4] xor w[4r+i-1] for i = 1..3.
  - Increment the counter. The edge that writes slot 10 moves the FSM to DONE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte, lower 24 bits zero.
- KEY_START while in EXPAND is ignored; no queueing.
- DONE holds the schedule indefinitely. KEY_START in DONE restarts as from IDLE, and KEY_DONE drops on that same edge.
- KEY_BUSY = (state==EXPAND); KEY_DONE = (state==DONE); both are registered-state decodes with no combinational path from inputs.
- All XOR arithmetic is 32-bit word-wise with no carries. The round counter is 4 bits and never exceeds 10; values 11..15 are unreachable and force IDLE.

## Timing
- Reset values:
  - KEY_SCHEDULE = 0, KEY_DONE = 0, KEY_BUSY = 0.
  - FSM = IDLE, counter = 0.
- Reset asserted mid-expansion aborts immediately and asynchronously to the reset values; no partial schedule survives.
- Latency: call the accepting edge T0. KEY_BUSY is high after T0. Slot r is valid after edge T0+r. KEY_DONE is high after T0+10, i.e. on the 11th edge counting T0. KEY_BUSY is low on the same edge.
- KEY_START held high continuously starts a new expansion on every edge at which the FSM is in IDLE or DONE, so DONE lasts one cycle per restart.
- Slot 0 is valid from T0 onward. The consumer must not use slots 1..10 before KEY_DONE.

## Configuration
- AES_KEYEXP_SBOX_PIPE_EN:
  - Defined: SubWord output is registered, so each round takes two EXPAND cycles (an S-box phase, then a write phase). Slot r becomes valid after edge T0+2r, KEY_DONE rises after T0+20, and a phase bit is added to the FSM.
  - Undefined: single-cycle rounds as above, latency 10.
- All other behaviour is identical in both builds.

## Structure
- Package aes_pkg holds:
  - typedef of the state enum (IDLE, EXPAND, DONE);
  - the round-key width (128) and count (11) constants;
  - the Rcon constant array;
  - the schedule width (1408).
- One sub-module, aes_sbox: a combinational 8-bit forward S-box. Four instances form SubWord. It is shared with the encryption path.

## Test plan
- Reset check: assert RESET mid-EXPAND (after 4 rounds) -> KEY_SCHEDULE = 0, KEY_DONE = 0 and KEY_BUSY = 0 immediately; the FSM then idles with no further writes.
- FIPS-197 C.1 vector: KEY_IN = 000102030405060708090a0b0c0d0e0f, one-cycle start.
  - Slot 1 = d6aa74fdd2af72fadaa678f1d6ab76fe after T0+1.
  - Slot 10 = 13111d7fe3944a17f307a78b4d2b30c5, with KEY_DONE rising exactly after T0+10.
- FIPS-197 A.1 vector: KEY_IN = 2b7e151628aed2a6abf7158809cf4f3c -> slot 1 = a0fafe1788542cb123a339392a6c7605 and slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start during busy: second KEY_START with a different key at T0+3 -> ignored. The schedule and timing match the first key and KEY_DONE still rises after T0+10.
- Restart from DONE: new key at the edge after KEY_DONE -> KEY_DONE falls on that edge, slots 1..10 read 0, and the new schedule completes 10 edges later.
- With AES_KEYEXP_SBOX_PIPE_EN defined, repeat C.1 -> identical slot values; KEY_DONE rises after T0+20 and slot 1 appears after T0+2.
